// File: rtl/bcd_bin_converter.sv
// bcd_bin_converter: iterative two-way binary/BCD converter.
// Mode 0 runs double-dabble (binary to BCD) and Mode 1 runs reverse
// double-dabble (BCD to binary). Each conversion takes one shift step
// per cycle, with a fixed latency of N cycles.
//
// Configuration macro: SIGNED_EN
//   Defined:   two's-complement V in Mode 0; SignIn applied in Mode 1.
//   Undefined: V is unsigned, Sign is constant 0 and SignIn is ignored.
//
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   synchronous active-high reset
//   Start    in   request, accepted only while Ready=1
//   Mode     in   0 = binary to BCD, 1 = BCD to binary
//   V        in   N-bit binary operand (Mode 0)
//   BcdIn    in   packed BCD operand (Mode 1), digit 0 in [3:0]
//   SignIn   in   sign of BcdIn (SIGNED_EN only)
//   Ready    out  idle, can accept Start
//   Done     out  one-cycle pulse, result registers updated
//   BCD      out  Mode 0 result
//   Bin      out  Mode 1 result
//   Sign     out  Mode 0 result sign
//   Overflow out  Mode 1 magnitude does not fit
//   Error    out  Mode 1 operand had a digit > 9

module bcd_bin_converter #(
    parameter int N = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Mode,
    input  logic [N-1:0]              V,
    input  logic [4*((N+2)/3)-1:0]    BcdIn,
    input  logic                      SignIn,
    output logic                      Ready,
    output logic                      Done,
    output logic [4*((N+2)/3)-1:0]    BCD,
    output logic [N-1:0]              Bin,
    output logic                      Sign,
    output logic                      Overflow,
    output logic                      Error
);

    localparam int DIGITS = (N + 2) / 3;
    localparam int DW     = 4 * DIGITS;
    localparam int W      = DW + N;
    localparam int CW     = $clog2(N);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    // FSM and working state
    logic          r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          r_inv;
    logic          r_vsign;
    logic          r_sign_in;
    logic [W-1:0]  r_work;

    // Result registers
    logic          r_done;
    logic [DW-1:0] r_bcd;
    logic [N-1:0]  r_bin;
    logic          r_sign;
    logic          r_ovf;
    logic          r_err;

    // Combinational step and result logic
    logic [W-1:0]  w_m0_adj;
    logic [W-1:0]  w_m0;
    logic [W-1:0]  w_m1_sh;
    logic [W-1:0]  w_m1;
    logic [W-1:0]  w_next;
    logic          w_last;
    logic          w_inv;
    logic [N-1:0]  w_vmag;
    logic          w_vsign;
    logic [N-1:0]  w_res_bin;
    logic          w_resid;
    logic [N-1:0]  w_bin_out;
    logic          w_ovf;

    // Double-dabble step: correct the digits first, then shift left.
    // The MSB of the binary field carries into the LSB of digit 0.
    always_comb begin
        w_m0_adj = r_work;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_work[N+4*d +: 4] >= 4'd5) begin
                w_m0_adj[N+4*d +: 4] = r_work[N+4*d +: 4] + 4'd3;
            end
        end
        w_m0 = w_m0_adj << 1;
    end

    // Reverse step: shift right first, then correct the digits.
    // The LSB of digit 0 falls into the MSB of the binary field.
    always_comb begin
        w_m1_sh = r_work >> 1;
        w_m1    = w_m1_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_m1_sh[N+4*d +: 4] >= 4'd8) begin
                w_m1[N+4*d +: 4] = w_m1_sh[N+4*d +: 4] - 4'd3;
            end
        end
    end

    assign w_next = r_mode ? w_m1 : w_m0;
    assign w_last = (r_cnt == CW'(N - 1));

    // Any digit above 9 in the incoming BCD operand
    always_comb begin
        w_inv = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (BcdIn[4*d +: 4] > 4'd9) begin
                w_inv = 1'b1;
            end
        end
    end

    // Any digits left over after N right shifts mean mag >= 2^N
    assign w_res_bin = w_next[N-1:0];
    assign w_resid   = |w_next[W-1:N];

`ifdef SIGNED_EN
    // The most negative value maps onto 2^(N-1), which is still
    // representable as an N-bit unsigned magnitude.
    assign w_vsign   = V[N-1];
    assign w_vmag    = V[N-1] ? (~V) + ONE_N : V;
    assign w_bin_out = r_sign_in ? (~w_res_bin) + ONE_N : w_res_bin;
    // A negative result may reach 2^(N-1) exactly; a positive one may not
    assign w_ovf     = w_resid |
                       (r_sign_in ? (w_res_bin[N-1] & (|w_res_bin[N-2:0]))
                                  : w_res_bin[N-1]);
`else
    logic w_unused_sign;
    assign w_unused_sign = SignIn ^ r_sign_in;
    assign w_vsign       = 1'b0;
    assign w_vmag        = V;
    assign w_bin_out     = w_res_bin;
    assign w_ovf         = w_resid;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_inv     <= 1'b0;
            r_vsign   <= 1'b0;
            r_sign_in <= 1'b0;
            r_work    <= '0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                        r_mode  <= Mode;
                        r_vsign <= w_vsign;
`ifdef SIGNED_EN
                        r_sign_in <= SignIn;
`else
                        r_sign_in <= 1'b0;
`endif
                        if (Mode) begin
                            r_inv <= w_inv;
                            // An invalid operand still runs N steps,
                            // but on an all-zero register.
                            r_work <= w_inv ? '0 : {BcdIn, {N{1'b0}}};
                        end else begin
                            r_inv  <= 1'b0;
                            r_work <= {{DW{1'b0}}, w_vmag};
                        end
                    end
                end
                S_BUSY: begin
                    r_work <= w_next;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        if (!r_mode) begin
                            r_bcd  <= w_next[W-1:N];
                            r_bin  <= '0;
                            r_sign <= r_vsign;
                            r_ovf  <= 1'b0;
                            r_err  <= 1'b0;
                        end else if (r_inv) begin
                            r_bcd  <= '0;
                            r_bin  <= '0;
                            r_sign <= 1'b0;
                            r_ovf  <= 1'b0;
                            r_err  <= 1'b1;
                        end else begin
                            r_bcd  <= '0;
                            r_bin  <= w_bin_out;
                            r_sign <= 1'b0;
                            r_ovf  <= w_ovf;
                            r_err  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Ready    = (r_state == S_IDLE);
    assign Done     = r_done;
    assign BCD      = r_bcd;
    assign Bin      = r_bin;
    assign Sign     = r_sign;
    assign Overflow = r_ovf;
    assign Error    = r_err;

endmodule

// File: tb/tb_bcd_bin_converter.sv
// Testbench for bcd_bin_converter.
// Directed vectors feed a scoreboard queue that a Done monitor drains.

module tb_bcd_bin_converter;

    localparam int N  = 16;
    localparam int DW = 24;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Mode = 1'b0;
    logic [N-1:0]  V = '0;
    logic [DW-1:0] BcdIn = '0;
    logic          SignIn = 1'b0;
    logic          Ready;
    logic          Done;
    logic [DW-1:0] BCD;
    logic [N-1:0]  Bin;
    logic          Sign;
    logic          Overflow;
    logic          Error;

    bcd_bin_converter #(.N(N)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Mode     (Mode),
        .V        (V),
        .BcdIn    (BcdIn),
        .SignIn   (SignIn),
        .Ready    (Ready),
        .Done     (Done),
        .BCD      (BCD),
        .Bin      (Bin),
        .Sign     (Sign),
        .Overflow (Overflow),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    // Count of rising edges seen so far
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] bcd;
        logic [N-1:0]  bin;
        logic          sign;
        logic          ovf;
        logic          err;
        int            t;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest expectation
    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 expected 0 (cycle %0d)",
                         cyc);
            end else begin
                m_e = sbq.pop_front();
                chk("bcd", 32'(BCD), 32'(m_e.bcd));
                chk("bin", 32'(Bin), 32'(m_e.bin));
                chk("sign", 32'(Sign), 32'(m_e.sign));
                chk("overflow", 32'(Overflow), 32'(m_e.ovf));
                chk("error", 32'(Error), 32'(m_e.err));
                chk("latency", 32'(cyc - m_e.t), 32'(N));
                chk("ready_at_done", 32'(Ready), 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (Ready !== 1'b1 && k < 100) begin
            @(negedge Clock);
            k++;
        end
        if (Ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got Ready=%b expected 1", Ready);
        end
    endtask

    task automatic issue(input logic m, input logic [N-1:0] v,
                         input logic [DW-1:0] b, input logic s,
                         input logic [DW-1:0] ebcd, input logic [N-1:0] ebin,
                         input logic esign, input logic eovf,
                         input logic eerr, input bit poke);
        exp_t e;
        int busy;
        wait_ready();
        Mode   = m;
        V      = v;
        BcdIn  = b;
        SignIn = s;
        Start  = 1'b1;
        e.bcd  = ebcd;
        e.bin  = ebin;
        e.sign = esign;
        e.ovf  = eovf;
        e.err  = eerr;
        e.t    = cyc + 1;
        sbq.push_back(e);
        @(negedge Clock);
        Start = 1'b0;
        busy  = 0;
        for (int i = 0; i < N; i++) begin
            if (Ready === 1'b0) busy++;
            if (poke) begin
                // Start pulses and operand changes while busy are ignored
                Start = (i == 3 || i == 9);
                V     = ~v;
                BcdIn = 24'h999999;
                Mode  = ~m;
            end
            @(negedge Clock);
        end
        Start = 1'b0;
        chk("busy_cycles", 32'(busy), 32'(N));
    endtask

    initial begin
        int k;
        int t0;
        exp_t e;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_bcd", 32'(BCD), 32'd0);
        chk("rst_bin", 32'(Bin), 32'd0);
        chk("rst_flags", {29'd0, Sign, Overflow, Error}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

`ifdef SIGNED_EN
        issue(1'b0, 16'hFFFF, '0, 1'b0, 24'h000001, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'h8000, '0, 1'b0, 24'h032768, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'h7FFF, '0, 1'b0, 24'h032767, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h032768, 1'b1, 24'h0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h032768, 1'b0, 24'h0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h032767, 1'b0, 24'h0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h000001, 1'b1, 24'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h065535, 1'b0, 24'h0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        issue(1'b0, 16'hFFFF, '0, 1'b0, 24'h065535, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 16'h8000, '0, 1'b1, 24'h032768, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h065535, 1'b1, 24'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h065536, 1'b0, 24'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        issue(1'b0, 16'd1234, '0, 1'b0, 24'h001234, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 16'd0, '0, 1'b0, 24'h000000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h012345, 1'b0, 24'h0, 16'h3039, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, '0, 24'h00A123, 1'b0, 24'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b1, '0, 24'h000000, 1'b0, 24'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, '0, 24'h999999, 1'b0, 24'h0, 16'h423F, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start held high: one acceptance every N+1 cycles
        wait_ready();
        Mode   = 1'b1;
        BcdIn  = 24'h012345;
        SignIn = 1'b0;
        Start  = 1'b1;
        t0     = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.bcd  = '0;
            e.bin  = 16'h3039;
            e.sign = 1'b0;
            e.ovf  = 1'b0;
            e.err  = 1'b0;
            e.t    = t0 + i * (N + 1);
            sbq.push_back(e);
        end
        repeat (40) @(negedge Clock);
        Start = 1'b0;
        k = 0;
        while (sbq.size() > 0 && k < 200) begin
            @(negedge Clock);
            k++;
        end
        chk("stream_drained", 32'(sbq.size()), 32'd0);

        // Abort at step 8: no Done, all results cleared
        wait_ready();
        Mode  = 1'b0;
        V     = 16'd4321;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (8) @(negedge Clock);
        chk("abort_busy", 32'(Ready), 32'd0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("abort_ready", 32'(Ready), 32'd1);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_bcd", 32'(BCD), 32'd0);
        chk("abort_bin", 32'(Bin), 32'd0);
        chk("abort_flags", {29'd0, Sign, Overflow, Error}, 32'd0);
        Reset = 1'b0;
        repeat (N + 8) @(negedge Clock);

        // Reset and Start on the same edge: Reset wins
        Reset = 1'b1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Reset = 1'b0;
        chk("reset_wins_ready", 32'(Ready), 32'd1);
        @(negedge Clock);
        chk("reset_wins_idle", 32'(Ready), 32'd1);
        repeat (N + 4) @(negedge Clock);

        k = 0;
        while (sbq.size() > 0 && k < 200) begin
            @(negedge Clock);
            k++;
        end
        chk("queue_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
